sym_seq_gen: RTL

//  Transmit side of the 2-bit symbol stream {i1,i0} consumed by the lab sequence recognizer.

---
 rtl/sym_pkg.sv | 8 +
 rtl/sym_buf.sv | 17 +
 rtl/sym_seq_gen.sv | 70 +++++++
 3 files changed

// File: rtl/sym_pkg.sv
// sym_pkg: symbol codes and FSM encoding shared by the symbol sequence generator.
package sym_pkg;
    localparam logic [1:0] SYM_A   = 2'b00;
    localparam logic [1:0] SYM_B   = 2'b01;
    localparam logic [1:0] SYM_D   = 2'b10;
    localparam logic [1:0] SYM_RST = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_SEND, ST_DONE} state_t;
endpackage

// File: rtl/sym_buf.sv
// sym_buf: DEPTH x 2-bit frame store, synchronous write, asynchronous read, no storage reset.
module sym_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);
    logic [1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/sym_seq_gen.sv
// sym_seq_gen: buffers a frame of 2-bit symbols and streams 11 then the frame over valid/ready.
module sym_seq_gen
    import sym_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_sym,
    input  logic       clr,
    input  logic       start,
    input  logic       sym_ready,
    output logic       i1_o,
    output logic       i0_o,
    output logic       sym_valid,
    output logic       busy,
    output logic       done,
    output logic       full,
    output logic       rej
);
    state_t        state, state_n;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    rd_sym;
    logic          idle, store, last, accept;
    assign idle      = state == ST_IDLE;
    assign full      = count == (AW+1)'(DEPTH);
    assign store     = idle & wr_en & ~clr & ~full & (wr_sym != SYM_RST);
    assign sym_valid = (state == ST_PRE) | (state == ST_SEND);
    assign busy      = sym_valid;
    assign accept    = sym_valid & sym_ready;
    assign last      = ({1'b0, rd_ptr} + (AW+1)'(1)) == count;
    assign done      = state == ST_DONE;
    assign {i1_o, i0_o} = state == ST_PRE ? SYM_RST : state == ST_SEND ? rd_sym : 2'b00;
    sym_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (store),
        .waddr (count[AW-1:0]),
        .wdata (wr_sym),
        .raddr (rd_ptr),
        .rdata (rd_sym)
    );
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start && count != '0) state_n = ST_PRE;
            ST_PRE:  if (accept) state_n = ST_SEND;
            ST_SEND: if (accept && last) state_n = ST_DONE;
            default: state_n = ST_IDLE;
        endcase
    end
    // clr suppresses rej even when paired with a write that would otherwise be dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            rd_ptr <= '0;
            rej    <= 1'b0;
        end else begin
            state <= state_n;
            rej   <= wr_en & ~clr & (~idle | full | (wr_sym == SYM_RST));
            if (idle && clr) count <= '0;
            else if (store) count <= count + (AW+1)'(1);
            if (state == ST_PRE) rd_ptr <= '0;
            else if (state == ST_SEND && accept) rd_ptr <= rd_ptr + AW'(1);
        end
    end
endmodule
